// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM bank: counting mode and counter direction.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: tick is high on the clock where the count equals pre_div.
module pwm_prescaler #(
  parameter int PRE = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [PRE-1:0] pre_div,
  output logic           tick
);

  logic [PRE-1:0] cnt;

  assign tick = en && (cnt == pre_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Bank of CH PWM channels sharing one edge/center-aligned counter, with
// double-buffered duty registers that swap in at each period boundary.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter  int CH  = 4,
  parameter  int CTR = 8,
  parameter  int PRE = 8,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [PRE-1:0] pre_div,
  input  logic           mode,
  input  logic           wr,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CTR-1:0] wr_val,
  output logic [CH-1:0]  sig,
  output logic           sync
);

  localparam logic [CTR-1:0] CMAX = '1;

  logic           tick;
  logic           bnd;
  logic           mode_l;
  logic [CTR-1:0] ctr;
  logic [CTR-1:0] ctr_nxt;
  dir_t           dir;
  dir_t           dir_nxt;

  pwm_prescaler #(.PRE(PRE)) u_pre (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pre_div (pre_div),
    .tick    (tick)
  );

  // Next counter value; any tick that lands the counter on 0 starts a new period.
  always_comb begin
    ctr_nxt = ctr;
    dir_nxt = dir;
    if (tick) begin
      if (mode_l == MODE_EDGE) begin
        ctr_nxt = ctr + 1'b1;
      end else if (dir == UP) begin
        if (ctr == CMAX) begin
          ctr_nxt = ctr - 1'b1;
          dir_nxt = DOWN;
        end else begin
          ctr_nxt = ctr + 1'b1;
        end
      end else begin
        ctr_nxt = ctr - 1'b1;
      end
    end
    if (ctr_nxt == '0) begin
      dir_nxt = UP;
    end
    bnd = tick && (ctr_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr    <= '0;
      dir    <= UP;
      mode_l <= MODE_EDGE;
      sync   <= 1'b0;
    end else if (!en) begin
      ctr    <= '0;
      dir    <= UP;
      sync   <= 1'b0;
    end else begin
      ctr  <= ctr_nxt;
      dir  <= dir_nxt;
      sync <= bnd;
      if (bnd) begin
        mode_l <= mode;
      end
    end
  end

  // Out-of-range wr_ch matches no channel, so such writes fall away naturally.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic           hit;
    logic           s;
    logic [CTR-1:0] shadow;
    logic [CTR-1:0] active;

    assign hit    = wr && (32'(wr_ch) == 32'(i));
    assign sig[i] = s;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        shadow <= '0;
        active <= '0;
        s      <= 1'b0;
      end else begin
        if (hit) begin
          shadow <= wr_val;
        end
        if (!en || bnd) begin
          active <= hit ? wr_val : shadow;
        end
        s <= en && (ctr < active);
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: a phase-based period model checked every
// cycle, plus directed scenarios with hand-computed high-time and period counts.
module tb_pwm_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] pre_div;
  logic       mode;
  logic       wr;
  logic [1:0] wr_ch;
  logic [7:0] wr_val;
  logic [3:0] sig;
  logic       sync;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_bank #(.CH(4), .CTR(8), .PRE(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pre_div (pre_div),
    .mode    (mode),
    .wr      (wr),
    .wr_ch   (wr_ch),
    .wr_val  (wr_val),
    .sig     (sig),
    .sync    (sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position within a period is a plain phase index; the counter value
  // is derived from it (center mode folds the second half back down).
  int         m_pcnt;
  int         m_phase;
  bit         m_mode;
  int         m_sh  [4];
  int         m_act [4];
  bit [3:0]   m_sig;
  bit         m_sync;
  bit         m_tick;
  bit         m_bnd;
  int         m_c;
  bit [3:0]   m_nsig;

  function automatic int period_len(bit md);
    return md ? 510 : 256;
  endfunction

  function automatic int ctr_at(int ph, bit md);
    return (md && ph > 255) ? 510 - ph : ph;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pcnt  = 0;
      m_phase = 0;
      m_mode  = 1'b0;
      m_sig   = '0;
      m_sync  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_sh[i]  = 0;
        m_act[i] = 0;
      end
    end else if (!en) begin
      m_pcnt  = 0;
      m_phase = 0;
      m_sig   = '0;
      m_sync  = 1'b0;
      if (wr) m_sh[wr_ch] = int'(wr_val);
      for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
    end else begin
      m_tick = (m_pcnt == int'(pre_div));
      m_pcnt = m_tick ? 0 : (m_pcnt + 1) % 256;
      m_c    = ctr_at(m_phase, m_mode);
      for (int i = 0; i < 4; i++) m_nsig[i] = (m_c < m_act[i]);
      m_bnd = 1'b0;
      if (m_tick) begin
        m_phase = m_phase + 1;
        if (m_phase == period_len(m_mode)) begin
          m_phase = 0;
          m_bnd   = 1'b1;
        end
      end
      if (wr) m_sh[wr_ch] = int'(wr_val);
      if (m_bnd) begin
        for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
        m_mode = mode;
      end
      m_sig  = m_nsig;
      m_sync = m_bnd;
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if (sig !== m_sig || sync !== m_sync) begin
      n_fail++;
      if (n_fail <= 20)
        $display("[TB] FAIL model_cycle t=%0t sig=%b sync=%b expected sig=%b sync=%b",
                 $time, sig, sync, m_sig, m_sync);
    end
  end

  // Directed-scenario accumulators, sampled on falling edges.
  int acc_len;
  int acc_hi [4];
  bit last_sync;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    acc_len++;
    for (int i = 0; i < 4; i++) acc_hi[i] += int'(sig[i]);
    last_sync = sync;
  endtask

  task automatic clear_acc();
    acc_len = 0;
    for (int i = 0; i < 4; i++) acc_hi[i] = 0;
  endtask

  task automatic wait_sync(input string name);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!last_sync && k < 3000);
    if (!last_sync) checkOutput({name, "_timeout"}, int'(last_sync), 1);
  endtask

  task automatic applyStimulus(input int ch, input int val);
    wr     = 1'b1;
    wr_ch  = 2'(ch);
    wr_val = 8'(val);
    step();
    wr     = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; pre_div = 8'd0; mode = 1'b0;
    wr = 1'b0; wr_ch = 2'd0; wr_val = 8'd0;
    clear_acc();
    repeat (3) step();
    checkOutput("reset_sig", int'(sig), 0);
    checkOutput("reset_sync", int'(sync), 0);

    rst = 1'b1;
    step();
    en = 1'b1;
    applyStimulus(0, 128);
    applyStimulus(1, 0);
    applyStimulus(2, 255);
    applyStimulus(3, 30);
    wait_sync("first_boundary");
    clear_acc();
    wait_sync("edge_period");
    checkOutput("edge_len", acc_len, 256);
    checkOutput("half_hi0", acc_hi[0], 128);
    checkOutput("zero_hi1", acc_hi[1], 0);
    checkOutput("max_hi2", acc_hi[2], 255);
    checkOutput("ch3_hi", acc_hi[3], 30);

    clear_acc();
    repeat (50) step();
    applyStimulus(3, 90);
    applyStimulus(3, 60);
    wait_sync("shadow_period");
    checkOutput("shadow_cur_hi3", acc_hi[3], 30);
    checkOutput("shadow_cur_len", acc_len, 256);
    clear_acc();
    wait_sync("shadow_next");
    checkOutput("shadow_next_hi3", acc_hi[3], 60);

    pre_div = 8'd3;
    clear_acc();
    wait_sync("prescale_period");
    checkOutput("prescale_len", acc_len, 1024);
    checkOutput("prescale_hi0", acc_hi[0], 512);

    pre_div = 8'd0;
    mode = 1'b1;
    applyStimulus(0, 64);
    wait_sync("center_load");
    clear_acc();
    wait_sync("center_period");
    checkOutput("center_len", acc_len, 510);
    checkOutput("center_hi0", acc_hi[0], 127);
    checkOutput("center_hi1", acc_hi[1], 0);
    checkOutput("center_hi2", acc_hi[2], 509);

    mode = 1'b0;
    en = 1'b0;
    repeat (5) step();
    checkOutput("disabled_sig", int'(sig), 0);
    applyStimulus(1, 200);
    en = 1'b1;
    wait_sync("reenable_first");
    clear_acc();
    wait_sync("reenable_period");
    checkOutput("reenable_len", acc_len, 256);
    checkOutput("reenable_hi1", acc_hi[1], 200);

    repeat (40) step();
    checkOutput("pre_reset_sig2", int'(sig[2]), 1);
    #3 rst = 1'b0;
    #1;
    checkOutput("async_reset_sig", int'(sig), 0);
    checkOutput("async_reset_sync", int'(sync), 0);
    @(negedge clk);
    rst = 1'b1;
    clear_acc();
    wait_sync("post_reset_period");
    checkOutput("post_reset_len", acc_len, 256);
    checkOutput("post_reset_hi0", acc_hi[0], 0);
    checkOutput("post_reset_hi2", acc_hi[2], 0);
    applyStimulus(0, 10);
    wait_sync("post_reset_load");
    clear_acc();
    wait_sync("post_reset_run");
    checkOutput("post_reset_new_hi0", acc_hi[0], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter CH, default 4: number of PWM channels (1..16).
REQ-002 SHALL have parameter CTR, default 8: counter and duty width in bits.
REQ-003 SHALL have parameter PRE, default 8: prescaler divisor width in bits.
REQ-004 SHALL have port clk, input, 1 bit: clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1 bit: 1 = run; 0 = hold the counters at 0 and drive sig low.
REQ-007 SHALL have port pre_div, input, PRE bits: tick every pre_div+1 clocks.
REQ-008 SHALL have port mode, input, 1 bit: 0 = edge-aligned, 1 = center-aligned.
REQ-009 SHALL have port wr, input, 1 bit: write strobe, one cycle per write.
REQ-010 SHALL have port wr_ch, input, $clog2(CH) bits (minimum 1): target channel of the write.
REQ-011 SHALL have port wr_val, input, CTR bits: duty value written.
REQ-012 SHALL have port sig, output, CH bits: registered PWM outputs.
REQ-013 SHALL have port sync, output, 1 bit: one-clock pulse at each period start.

Function
REQ-014 SHALL run a prescaler counter 0..pre_div that asserts an internal tick on the clock where it equals pre_div, then wraps to 0; pre_div=0 gives a tick every clock.
REQ-015 In edge mode, the main counter SHALL advance 0,1,...,2^CTR-1,0 per tick, giving a period of 2^CTR ticks.
REQ-016 In center mode, the main counter SHALL count up 0..2^CTR-1, then down 2^CTR-2..1, then return to 0, giving a period of 2^(CTR+1)-2 ticks.
REQ-017 A period boundary SHALL occur on the tick that moves the main counter to 0.
REQ-018 Each channel SHALL hold a shadow duty register written when wr=1: shadow[wr_ch] <= wr_val.
REQ-019 Writes with wr_ch >= CH SHALL be ignored.
REQ-020 At a period boundary, every active duty register SHALL load from its shadow.
REQ-021 A write on the same clock as a boundary SHALL be loaded directly into active (write-through).
REQ-022 mode SHALL be sampled only at a period boundary; mid-period changes SHALL take effect next period.
REQ-023 Channel output SHALL be sig[i] <= (ctr < active[i]), registered, one clock after the counter value.
REQ-024 Boundary values: duty 0 SHALL give a constant-low output; duty 2^CTR-1 SHALL give a high output for all but one count per edge-mode period.
REQ-025 Multiple writes to one channel within a period SHALL resolve so that the last write wins.
REQ-026 sync SHALL pulse high for exactly one clock, aligned with the clock on which the active registers load.
REQ-027 While en=0:
- prescaler and main counter SHALL be held at 0;
- sig and sync SHALL be 0;
- active registers SHALL track the shadow registers each clock.
REQ-028 After en rises, the first tick SHALL occur pre_div+1 clocks later.

Reset
REQ-029 When rst=0, the following SHALL clear to 0 immediately, regardless of clk: prescaler, main counter, direction flag, latched mode, all shadow and active registers, sig, and sync.
REQ-030 Reset asserted mid-period SHALL abort the period; after release, operation SHALL restart from counter 0 with duty 0 on all channels.

Structure
REQ-031 A shared package pwm_pkg SHALL hold the mode constants MODE_EDGE=0 and MODE_CENTER=1 and the direction enum {UP, DOWN}.
REQ-032 The prescaler SHALL be a separate sub-module pwm_prescaler (clk, rst, en, pre_div -> tick).
REQ-033 The main counter and the per-channel logic SHALL reside in pwm_bank, with channels generated by a loop over CH.

Verification (CH=4, CTR=8, PRE=8)
REQ-034 Scenario "half duty": pre_div=0, edge mode, write ch0=128 -> after the first boundary, sig[0] is 128 clocks high then 128 low, and sync pulses every 256 clocks.
REQ-035 Scenario "extremes": ch1=0 and ch2=255 -> sig[1] stays low; sig[2] is high 255 of every 256 clocks.
REQ-036 Scenario "shadow": ch3=30 active; mid-period, write ch3=90 then ch3=60 -> the current period stays 30 high; the next period is 60 high.
REQ-037 Scenario "prescale": pre_div=3, ch0=128 -> period 1024 clocks, 512 clocks high, sync spacing 1024.
REQ-038 Scenario "center": mode=1, ch0=64 -> period 510 ticks, 127 ticks high, centered on ctr=0.
REQ-039 Scenario "async reset": assert rst=0 mid-period between clock edges -> sig=0 immediately; after release, all outputs stay low until new writes take effect at a boundary.
